instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Initiator side of the instruction-memory interface. Owns the PC and drives the word
//  address into the instruction memory (combinational read, same-cycle data). Latches the
//  returned word into an IF/ID register and hands it to decode with a valid/ready handshake.
//  Takes PC redirects from execute (branch/jump resolution), flushing the fetched slot.
// PARAMETERS
//  RESET_PC   0   word address fetched first after reset
//  MEM_WORDS  32  instruction memory depth in words, power of two; PC wraps modulo this
// PORTS
//  clock             in   1   single clock, all state on rising edge
//  reset             in   1   synchronous, active-high
//  imem_addr         out  32  word index to instruction memory ({0, pc[log2(MEM_WORDS)-1:0]})
//  imem_instruction  in   32  memory data for imem_addr, valid same cycle
//  if_valid          out  1   IF/ID slot holds an instruction
//  if_instruction    out  32  fetched instruction
//  if_pc             out  32  word address of if_instruction
//  if_pc_plus1       out  32  if_pc+1 (wrapped), for branch/link computation downstream
//  if_pred_taken     out  1   fetch redirected after this instruction (0 without macro)
//  id_ready          in   1   decode accepts slot this cycle when if_valid=1
//  ex_redirect       in   1   execute resolved a PC change / mispredict
//  ex_redirect_pc    in   32  word address to resume at when ex_redirect=1
// BEHAVIOUR
//  - Reset (edge with reset=1): pc<=RESET_PC, if_valid<=0, if_instruction<=0, if_pc<=0,
//    if_pc_plus1<=0, if_pred_taken<=0, state<=RUN. Reset overrides every other input.
//  - imem_addr = pc at all times (registered source, no combinational path from inputs).
//  - advance = !if_valid | id_ready. FSM states:
//    RUN:   if advance: IF/ID <= {imem_instruction, pc, pc+1}, if_valid<=1, pc<=next_pc.
//           if !advance: go HOLD, pc and IF/ID frozen.
//    HOLD:  outputs and imem_addr stable; on id_ready -> behave as RUN same edge.
//    FLUSH: entered on ex_redirect; if_valid=0 for this cycle; pc already = redirect
//           target; next edge fetches target -> RUN.
//  - ex_redirect (any state, beats id_ready/HOLD): pc<=ex_redirect_pc wrapped, if_valid<=0,
//    if_pred_taken<=0, state<=FLUSH. Slot content is discarded even if id_ready=1 that cycle.
//    Latency: redirect sampled at edge N -> target valid at if_* after edge N+1.
//  - Redirect asserted during FLUSH: honoured again (new target), stays FLUSH.
//  - next_pc default = pc+1 modulo MEM_WORDS; 31 -> 0 for MEM_WORDS=32. Upper pc bits 0.
//  - Throughput: one instruction/cycle with id_ready held 1; no duplication or skip across
//    HOLD periods of any length.
//  - First valid instruction: if_valid=1 after first edge with reset=0 (pc=RESET_PC).
// CONFIGURATION
//  IFETCH_STATIC_PREDICT_EN defined: during advance, the fetched word is pre-decoded:
//    opcode 000100/000101 (beq/bne) with imm[15]=1 -> next_pc = pc+1+sext(imm[15:0]);
//    opcode 000010 (j) -> next_pc = imm26 zero-extended; if_pred_taken<=1 for these.
//    Forward branches predicted not-taken. Execute corrects via ex_redirect as usual.
//  Not defined: next_pc always pc+1, if_pred_taken tied 0, no pre-decode logic.
// TESTING
//  1 mem[0..3]=A,B,C,D, id_ready=1, release reset -> cycles 1..4 if_instruction A..D,
//    if_pc 0..3, if_valid=0 while reset high.
//  2 id_ready=0 for 3 cycles with B in slot -> if_instruction=B, if_pc=1, imem_addr=2
//    stable; id_ready=1 -> C next, no B repeat or skip.
//  3 ex_redirect=1, ex_redirect_pc=9 while id_ready=0 -> next cycle if_valid=0; following
//    cycle if_pc=9, if_instruction=mem[9].
//  4 Run from pc=30, MEM_WORDS=32 -> if_pc sequence 30,31,0,1.
//  5 mem[9]=32'h1109FFFE (beq, imm -2): macro on -> next if_pc=8, if_pred_taken=1;
//    macro off -> next if_pc=10, if_pred_taken=0.
//  6 reset during HOLD (if_valid=1, id_ready=0) -> next cycle if_valid=0, imem_addr=RESET_PC;
//    reset same cycle as ex_redirect -> reset wins.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction memory and holds the IF/ID slot.
// Optional static branch prediction is enabled by defining IFETCH_STATIC_PREDICT_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus1,
  output logic        if_pred_taken,
  input  logic        id_ready,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [AW-1:0]   slot_pc_q, slot_pc_d;
  logic [AW-1:0]   slot_plus1_q, slot_plus1_d;
  logic            pred_q, pred_d;

  logic [AW-1:0]   pc_plus1;
  logic [AW-1:0]   next_pc;
  logic            pred_taken;
  logic            advance;
  logic            unused_redirect_bits;

  assign pc_plus1 = pc_q + 1'b1;

  // Only the low address bits matter: the PC wraps modulo the memory depth.
  assign unused_redirect_bits = ^ex_redirect_pc[31:AW];

`ifdef IFETCH_STATIC_PREDICT_EN
  logic [5:0]    opcode;
  logic [AW-1:0] branch_offset;
  logic [AW-1:0] jump_target;
  logic          is_back_branch;
  logic          is_jump;
  logic          unused_predict_bits;

  assign opcode = imem_instruction[31:26];

  // Sign-extension followed by wrap leaves only the low bits of the offset relevant.
  always_comb begin
    branch_offset  = imem_instruction[AW-1:0];
    jump_target    = imem_instruction[AW-1:0];
    is_back_branch = ((opcode == 6'b000100) || (opcode == 6'b000101)) && imem_instruction[15];
    is_jump        = (opcode == 6'b000010);
    pred_taken     = is_back_branch || is_jump;
    next_pc        = pc_plus1;
    if (is_jump) begin
      next_pc = jump_target;
    end else if (is_back_branch) begin
      next_pc = pc_plus1 + branch_offset;
    end
  end

  assign unused_predict_bits = ^imem_instruction[25:AW];
`else
  assign pred_taken = 1'b0;
  assign next_pc    = pc_plus1;
`endif

  always_comb begin
    case (state_q)
      FLUSH:   advance = 1'b1;
      HOLD:    advance = id_ready;
      default: advance = !valid_q || id_ready;
    endcase
  end

  // A redirect always wins over the handshake; the slot is discarded in its favour.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    slot_pc_d    = slot_pc_q;
    slot_plus1_d = slot_plus1_q;
    pred_d       = pred_q;
    if (ex_redirect) begin
      pc_d    = ex_redirect_pc[AW-1:0];
      valid_d = 1'b0;
      pred_d  = 1'b0;
      state_d = FLUSH;
    end else if (advance) begin
      instr_d      = imem_instruction;
      slot_pc_d    = pc_q;
      slot_plus1_d = pc_plus1;
      valid_d      = 1'b1;
      pred_d       = pred_taken;
      pc_d         = next_pc;
      state_d      = RUN;
    end else begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC[AW-1:0];
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      slot_pc_q    <= '0;
      slot_plus1_q <= '0;
      pred_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_plus1_q <= slot_plus1_d;
      pred_q       <= pred_d;
    end
  end

  assign imem_addr      = {{(32-AW){1'b0}}, pc_q};
  assign if_valid       = valid_q;
  assign if_instruction = instr_q;
  assign if_pc          = {{(32-AW){1'b0}}, slot_pc_q};
  assign if_pc_plus1    = {{(32-AW){1'b0}}, slot_plus1_q};
  assign if_pred_taken  = pred_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle table plus a handshake throughput sequence.
module tb_instruction_fetch;

`ifdef IFETCH_STATIC_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus1;
  logic        if_pred_taken;
  logic        id_ready;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;

  int passCount;
  int checkCount;

  logic [31:0] mem [32];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    int          mode;
    logic        expValid;
    logic [31:0] expAddr;
    logic [31:0] expPc;
    logic        expPred;
  } vec_t;

  vec_t vecs [26];

  instruction_fetch #(.RESET_PC(32'd0), .MEM_WORDS(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_pc_plus1      (if_pc_plus1),
    .if_pred_taken    (if_pred_taken),
    .id_ready         (id_ready),
    .ex_redirect      (ex_redirect),
    .ex_redirect_pc   (ex_redirect_pc)
  );

  // Combinational memory model, same-cycle data for the presented address.
  assign imem_instruction = mem[imem_addr[4:0]];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] memWord(input int idx);
    if (idx == 9) return 32'h1109FFFE;
    return 32'hC0DE0000 | idx;
  endfunction

  // mode 0: valid and address only; 1: full slot; 2: slot cleared by reset
  function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                              input logic [31:0] rpc, input int mode, input logic v,
                              input logic [31:0] addr, input logic [31:0] pc, input logic pr);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.redir = redir; r.rpc = rpc; r.mode = mode;
    r.expValid = v; r.expAddr = addr; r.expPc = pc; r.expPred = pr;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    reset          = rst;
    id_ready       = rdy;
    ex_redirect    = redir;
    ex_redirect_pc = rpc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] predPc;
    logic [15:0] pattern;
    logic [31:0] expectPc;
    int          accepted;

    passCount  = 0;
    checkCount = 0;
    reset          = 1'b1;
    id_ready       = 1'b1;
    ex_redirect    = 1'b0;
    ex_redirect_pc = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = memWord(i);

    predPc = PRED ? 32'd8 : 32'd10;

    vecs[0]  = mk(1, 1, 0, 0,  2, 0, 0,  0,  0);
    vecs[1]  = mk(0, 1, 0, 0,  1, 1, 1,  0,  0);
    vecs[2]  = mk(0, 1, 0, 0,  1, 1, 2,  1,  0);
    vecs[3]  = mk(0, 0, 0, 0,  1, 1, 2,  1,  0);
    vecs[4]  = mk(0, 0, 0, 0,  1, 1, 2,  1,  0);
    vecs[5]  = mk(0, 0, 0, 0,  1, 1, 2,  1,  0);
    vecs[6]  = mk(0, 1, 0, 0,  1, 1, 3,  2,  0);
    vecs[7]  = mk(0, 1, 0, 0,  1, 1, 4,  3,  0);
    vecs[8]  = mk(0, 0, 1, 9,  0, 0, 9,  0,  0);
    vecs[9]  = mk(0, 0, 0, 0,  1, 1, predPc, 9, PRED);
    vecs[10] = mk(0, 1, 0, 0,  1, 1, predPc + 1, predPc, 0);
    vecs[11] = mk(0, 1, 1, 30, 0, 0, 30, 0,  0);
    vecs[12] = mk(0, 1, 0, 0,  1, 1, 31, 30, 0);
    vecs[13] = mk(0, 1, 0, 0,  1, 1, 0,  31, 0);
    vecs[14] = mk(0, 1, 0, 0,  1, 1, 1,  0,  0);
    vecs[15] = mk(0, 1, 0, 0,  1, 1, 2,  1,  0);
    vecs[16] = mk(0, 0, 0, 0,  1, 1, 2,  1,  0);
    vecs[17] = mk(1, 0, 0, 0,  2, 0, 0,  0,  0);
    vecs[18] = mk(1, 1, 1, 5,  2, 0, 0,  0,  0);
    vecs[19] = mk(0, 1, 0, 0,  1, 1, 1,  0,  0);
    vecs[20] = mk(0, 1, 1, 3,  0, 0, 3,  0,  0);
    vecs[21] = mk(0, 1, 1, 7,  0, 0, 7,  0,  0);
    vecs[22] = mk(0, 1, 0, 0,  1, 1, 8,  7,  0);
    vecs[23] = mk(0, 1, 1, 40, 0, 0, 8,  0,  0);
    vecs[24] = mk(0, 1, 0, 0,  1, 1, 9,  8,  0);
    vecs[25] = mk(0, 1, 0, 0,  1, 1, predPc, 9, PRED);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      checkOutput($sformatf("v%0d valid", i), {31'd0, if_valid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].expAddr);
      if (vecs[i].mode == 1) begin
        checkOutput($sformatf("v%0d if_pc", i), if_pc, vecs[i].expPc);
        checkOutput($sformatf("v%0d if_instruction", i), if_instruction,
                    memWord(int'(vecs[i].expPc)));
        checkOutput($sformatf("v%0d if_pc_plus1", i), if_pc_plus1,
                    (vecs[i].expPc + 32'd1) & 32'd31);
        checkOutput($sformatf("v%0d pred", i), {31'd0, if_pred_taken}, {31'd0, vecs[i].expPred});
      end else if (vecs[i].mode == 2) begin
        checkOutput($sformatf("v%0d reset if_pc", i), if_pc, 32'd0);
        checkOutput($sformatf("v%0d reset if_instruction", i), if_instruction, 32'd0);
        checkOutput($sformatf("v%0d reset if_pc_plus1", i), if_pc_plus1, 32'd0);
        checkOutput($sformatf("v%0d reset pred", i), {31'd0, if_pred_taken}, 32'd0);
      end
    end

    // Consumer with a stalling ready pattern must see 12,13,14,... with no gaps or repeats.
    pattern  = 16'hB1D3;
    expectPc = 32'd12;
    accepted = 0;
    applyStimulus(0, 0, 1, 12);
    for (int k = 0; k < 16; k++) begin
      reset       = 1'b0;
      ex_redirect = 1'b0;
      id_ready    = pattern[k];
      #1;
      if (if_valid && id_ready) begin
        checkOutput($sformatf("tput%0d if_pc", k), if_pc, expectPc);
        checkOutput($sformatf("tput%0d if_instruction", k), if_instruction,
                    memWord(int'(expectPc)));
        expectPc = expectPc + 1;
        accepted++;
      end
      @(posedge clock);
      #1;
    end
    checkOutput("tput accepted count", accepted, 32'd8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
